// File: rtl/datapath_mc.sv
// Multi-cycle CPU datapath: register file, PC, instruction register and a req/ack memory sequencer.
// Optional DP_AUTO_INC_EN: PC advances by one when a fetch completes, unless pc_en claims that cycle.
module datapath_mc #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int NUM_REGS   = 16,
  parameter int IMM_WIDTH  = 8,
  localparam int REG_SEL_W = $clog2(NUM_REGS)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REGS-1:0]            reg_we,
  input  logic [REG_SEL_W-1:0]           rdest_sel,
  input  logic [REG_SEL_W-1:0]           rsrc_sel,
  input  logic [IMM_WIDTH-1:0]           imm_in,
  input  logic                           imm_sel,
  input  logic                           imm_sext,
  output logic [DATA_WIDTH-1:0]          alu_a,
  output logic [DATA_WIDTH-1:0]          alu_b,
  input  logic [DATA_WIDTH-1:0]          alu_result,
  input  logic                           wb_sel,
  input  logic                           pc_en,
  input  logic                           pc_branch,
  input  logic signed [DATA_WIDTH-1:0]   pc_offset,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic [1:0]                     cmd_op,
  output logic                           mem_req,
  output logic                           mem_we,
  output logic [ADDR_WIDTH-1:0]          mem_addr,
  output logic [DATA_WIDTH-1:0]          mem_wdata,
  input  logic [DATA_WIDTH-1:0]          mem_rdata,
  input  logic                           mem_ack,
  output logic [DATA_WIDTH-1:0]          instr,
  output logic                           instr_valid,
  output logic                           busy,
  output logic [DATA_WIDTH-1:0]          pc_count,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_flat
);

  typedef enum logic {IDLE, WAIT} state_e;
  typedef enum logic [1:0] {OP_FETCH = 2'b00, OP_LOAD = 2'b01, OP_STORE = 2'b10, OP_NOP = 2'b11} op_e;

  state_e                 state, state_nxt;
  op_e                    op_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [DATA_WIDTH-1:0]  wdata_q;
  logic [REG_SEL_W-1:0]   dest_q;
  logic [DATA_WIDTH-1:0]  regs [NUM_REGS];
  logic [DATA_WIDTH-1:0]  pc, pc_nxt;
  logic [DATA_WIDTH-1:0]  ld_data;
  logic [DATA_WIDTH-1:0]  wb_val;
  logic                   accept, done, fetch_done, load_done;

  function automatic logic signed [DATA_WIDTH-1:0] ext_imm(input logic [IMM_WIDTH-1:0] imm,
                                                           input logic sext);
    if (sext) return DATA_WIDTH'($signed(imm));
    return $signed(DATA_WIDTH'(imm));
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (cmd_valid && cmd_op != OP_NOP) begin
        accept    = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: if (mem_ack) begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign fetch_done = done && (op_q == OP_FETCH);
  assign load_done  = done && (op_q == OP_LOAD);

  // Transaction latches: hold address/data stable for the whole WAIT period
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q    <= OP_NOP;
      addr_q  <= '0;
      wdata_q <= '0;
      dest_q  <= '0;
    end else if (accept) begin
      op_q   <= op_e'(cmd_op);
      dest_q <= rdest_sel;
      case (op_e'(cmd_op))
        OP_FETCH: addr_q <= pc[ADDR_WIDTH-1:0];
        OP_LOAD:  addr_q <= regs[rsrc_sel][ADDR_WIDTH-1:0];
        default: begin
          addr_q  <= regs[rdest_sel][ADDR_WIDTH-1:0];
          wdata_q <= regs[rsrc_sel];
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr       <= '0;
      instr_valid <= 1'b0;
      ld_data     <= '0;
    end else begin
      if (accept && op_e'(cmd_op) == OP_FETCH) instr_valid <= 1'b0;
      if (fetch_done) begin
        instr       <= mem_rdata;
        instr_valid <= 1'b1;
      end
      if (load_done) ld_data <= mem_rdata;
    end
  end

  assign wb_val = wb_sel ? ld_data : alu_result;

  // Load write-back takes priority over reg_we on the same register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (load_done && dest_q == REG_SEL_W'(i)) regs[i] <= mem_rdata;
        else if (reg_we[i])                       regs[i] <= wb_val;
      end
    end
  end

  always_comb begin
    pc_nxt = pc;
    if (pc_en) begin
      if (pc_branch) pc_nxt = DATA_WIDTH'($signed(pc) + pc_offset);
      else           pc_nxt = pc + DATA_WIDTH'(1);
    end
`ifdef DP_AUTO_INC_EN
    else if (fetch_done) pc_nxt = pc + DATA_WIDTH'(1);
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc <= '0;
    else       pc <= pc_nxt;
  end

  assign alu_a     = regs[rdest_sel];
  assign alu_b     = imm_sel ? ext_imm(imm_in, imm_sext) : regs[rsrc_sel];
  assign cmd_ready = (state == IDLE);
  assign busy      = (state == WAIT);
  assign mem_req   = (state == WAIT);
  assign mem_we    = (state == WAIT) && (op_q == OP_STORE);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign pc_count  = pc;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign reg_flat[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
  end

endmodule
